// File: rtl/dht11_frame_if.sv
// Frame-in / reading-out bundle between the DHT11 capture stage and the frame decoder.
interface dht11_frame_if #(
    parameter int unsigned ERR_W = 8
);
    logic [39:0]      frame_in;
    logic             frame_stb;
    logic [7:0]       hum_raw;
    logic [7:0]       temp_raw;
    logic [11:0]      hum_bcd;
    logic [11:0]      temp_bcd;
    logic             out_valid;
    logic             crc_err;
    logic             busy;
    logic [ERR_W-1:0] err_cnt;
    logic [ERR_W-1:0] ovr_cnt;

    modport master (
        output frame_in, frame_stb,
        input  hum_raw, temp_raw, hum_bcd, temp_bcd, out_valid, crc_err, busy, err_cnt, ovr_cnt
    );

    modport slave (
        input  frame_in, frame_stb,
        output hum_raw, temp_raw, hum_bcd, temp_bcd, out_valid, crc_err, busy, err_cnt, ovr_cnt
    );
endinterface

// File: rtl/dht11_frame_decode.sv
// DHT11 frame decoder: checksum validation, binary-to-BCD conversion of the integer bytes,
// publication of the last good reading and saturating reject/overrun statistics.
module dht11_frame_decode #(
    parameter bit          CHECK_EN    = 1'b1,
    parameter bit          ZERO_IS_ERR = 1'b1,
    parameter int unsigned ERR_W       = 8
) (
    input logic         clk,
    input logic         nRST,
    dht11_frame_if.slave bus
);
    localparam int unsigned FRAME_W = 40;
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned BCD_W   = 12;
    localparam int unsigned SR_W    = BCD_W + BYTE_W;
    localparam int unsigned ITER_W  = 3;
    localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(BYTE_W - 1);
    localparam logic [ERR_W-1:0]  CNT_MAX   = {ERR_W{1'b1}};

    typedef enum logic [1:0] {IDLE, CHECK, CONV, DONE} state_t;

    state_t              state_q, state_d;
    logic [FRAME_W-1:0]  frame_q, frame_d;
    logic [SR_W-1:0]     hum_sr_q, hum_sr_d;
    logic [SR_W-1:0]     temp_sr_q, temp_sr_d;
    logic [ITER_W-1:0]   iter_q, iter_d;
    logic [BYTE_W-1:0]   hum_raw_q, hum_raw_d;
    logic [BYTE_W-1:0]   temp_raw_q, temp_raw_d;
    logic [BCD_W-1:0]    hum_bcd_q, hum_bcd_d;
    logic [BCD_W-1:0]    temp_bcd_q, temp_bcd_d;
    logic                out_valid_q, out_valid_d;
    logic                crc_err_q, crc_err_d;
    logic                busy_q, busy_d;
    logic [ERR_W-1:0]    err_cnt_q, err_cnt_d;
    logic [ERR_W-1:0]    ovr_cnt_q, ovr_cnt_d;

    logic [BYTE_W-1:0]   sum;
    logic                reject;
    logic [SR_W-1:0]     hum_step;
    logic [SR_W-1:0]     temp_step;

    // One double-dabble iteration: bias nibbles >= 5 by 3, then shift left.
    function automatic logic [SR_W-1:0] dabble_step(input logic [SR_W-1:0] sr);
        logic [SR_W-1:0] t;
        t = sr;
        for (int i = 0; i < 3; i++) begin
            if (t[BYTE_W+4*i +: 4] >= 4'd5) begin
                t[BYTE_W+4*i +: 4] = 4'(t[BYTE_W+4*i +: 4] + 4'd3);
            end
        end
        return {t[SR_W-2:0], 1'b0};
    endfunction

    always_comb begin
        state_d     = state_q;
        frame_d     = frame_q;
        hum_sr_d    = hum_sr_q;
        temp_sr_d   = temp_sr_q;
        iter_d      = iter_q;
        hum_raw_d   = hum_raw_q;
        temp_raw_d  = temp_raw_q;
        hum_bcd_d   = hum_bcd_q;
        temp_bcd_d  = temp_bcd_q;
        out_valid_d = 1'b0;
        crc_err_d   = 1'b0;
        err_cnt_d   = err_cnt_q;
        ovr_cnt_d   = ovr_cnt_q;

        sum       = BYTE_W'(frame_q[39:32] + frame_q[31:24] + frame_q[23:16] + frame_q[15:8]);
        reject    = (CHECK_EN && (sum != frame_q[7:0])) || (ZERO_IS_ERR && (frame_q == '0));
        hum_step  = dabble_step(hum_sr_q);
        temp_step = dabble_step(temp_sr_q);

        // Strobes arriving while a frame is in flight are counted and discarded.
        if (bus.frame_stb && (state_q != IDLE) && (ovr_cnt_q != CNT_MAX)) begin
            ovr_cnt_d = ERR_W'(ovr_cnt_q + 1'b1);
        end

        case (state_q)
            IDLE: begin
                if (bus.frame_stb) begin
                    frame_d = bus.frame_in;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (reject) begin
                    crc_err_d = 1'b1;
                    if (err_cnt_q != CNT_MAX) begin
                        err_cnt_d = ERR_W'(err_cnt_q + 1'b1);
                    end
                    state_d = IDLE;
                end else begin
                    hum_sr_d  = {{BCD_W{1'b0}}, frame_q[39:32]};
                    temp_sr_d = {{BCD_W{1'b0}}, frame_q[23:16]};
                    iter_d    = '0;
                    state_d   = CONV;
                end
            end
            CONV: begin
                hum_sr_d  = hum_step;
                temp_sr_d = temp_step;
                iter_d    = ITER_W'(iter_q + 1'b1);
                // Last iteration publishes straight from the step result so DONE carries the pulse.
                if (iter_q == LAST_ITER) begin
                    hum_bcd_d   = hum_step[SR_W-1:BYTE_W];
                    temp_bcd_d  = temp_step[SR_W-1:BYTE_W];
                    hum_raw_d   = frame_q[39:32];
                    temp_raw_d  = frame_q[23:16];
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q     <= IDLE;
            frame_q     <= '0;
            hum_sr_q    <= '0;
            temp_sr_q   <= '0;
            iter_q      <= '0;
            hum_raw_q   <= '0;
            temp_raw_q  <= '0;
            hum_bcd_q   <= '0;
            temp_bcd_q  <= '0;
            out_valid_q <= 1'b0;
            crc_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            err_cnt_q   <= '0;
            ovr_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            frame_q     <= frame_d;
            hum_sr_q    <= hum_sr_d;
            temp_sr_q   <= temp_sr_d;
            iter_q      <= iter_d;
            hum_raw_q   <= hum_raw_d;
            temp_raw_q  <= temp_raw_d;
            hum_bcd_q   <= hum_bcd_d;
            temp_bcd_q  <= temp_bcd_d;
            out_valid_q <= out_valid_d;
            crc_err_q   <= crc_err_d;
            busy_q      <= busy_d;
            err_cnt_q   <= err_cnt_d;
            ovr_cnt_q   <= ovr_cnt_d;
        end
    end

    assign bus.hum_raw   = hum_raw_q;
    assign bus.temp_raw  = temp_raw_q;
    assign bus.hum_bcd   = hum_bcd_q;
    assign bus.temp_bcd  = temp_bcd_q;
    assign bus.out_valid = out_valid_q;
    assign bus.crc_err   = crc_err_q;
    assign bus.busy      = busy_q;
    assign bus.err_cnt   = err_cnt_q;
    assign bus.ovr_cnt   = ovr_cnt_q;
endmodule
